// File: rtl/parking_pkg.sv
// parking_pkg: shared FSM states, gate directions and occupancy sizing for the parking gate.
package parking_pkg;
  typedef enum logic [1:0] {IDLE, ARB, OPEN, HOLD} state_t;
  localparam logic DIR_ENTRY = 1'b0;
  localparam logic DIR_EXIT = 1'b1;
  function automatic int occ_width(input int cap);
    return $clog2(cap + 1);
  endfunction
endpackage

// File: rtl/parking_gate_rise_detect.sv
// rise_detect: registers a level once and flags its rising edge for one cycle.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic cur, prev;
  always_ff @(posedge clk)
    if (rst) begin
      cur <= 1'b0;
      prev <= 1'b0;
    end else begin
      cur <= d;
      prev <= cur;
    end
  assign rise = cur & ~prev;
endmodule

// File: rtl/parking_gate_controller.sv
// parking_gate_controller: arbitrates entry/exit requests for one gate and tracks occupancy;
// PARK_EXIT_PRIORITY_EN selects fixed exit priority on ties instead of round-robin.
module parking_gate_controller
  import parking_pkg::*;
#(
  parameter int CAPACITY = 8,
  parameter int PASS_TIMEOUT = 1_000_000,
  parameter int HOLDOFF = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic entry_req,
  input  logic exit_req,
  input  logic car_passed,
  output logic gate_open,
  output logic grant_dir,
  output logic reject,
  output logic timeout,
  output logic [occ_width(CAPACITY)-1:0] occupancy,
  output logic full,
  output logic empty
);
  localparam int OW = occ_width(CAPACITY);
  localparam int TW = $clog2((PASS_TIMEOUT > HOLDOFF ? PASS_TIMEOUT : HOLDOFF) + 1);
  state_t state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [OW-1:0] occ_n;
  logic in_rise, out_rise, pass_rise;
  logic pend_in, pend_out, pass_q;
  logic sel, feasible, clr_in, clr_out, grant_n, rej_n, to_n;
  rise_detect u_in (.clk(clk), .rst(rst), .d(entry_req), .rise(in_rise));
  rise_detect u_out (.clk(clk), .rst(rst), .d(exit_req), .rise(out_rise));
  rise_detect u_pass (.clk(clk), .rst(rst), .d(car_passed), .rise(pass_rise));
  assign full = occupancy == OW'(CAPACITY);
  assign empty = occupancy == '0;
`ifdef PARK_EXIT_PRIORITY_EN
  assign sel = pend_out;
`else
  logic last_dir;
  assign sel = (pend_in && pend_out) ? ~last_dir : pend_out;
  always_ff @(posedge clk)
    if (rst) last_dir <= DIR_EXIT;
    else if (state == ARB && feasible) last_dir <= sel;
`endif
  assign feasible = (sel == DIR_EXIT) ? !empty : !full;
  always_comb begin
    state_n = state;
    timer_n = timer;
    occ_n = occupancy;
    grant_n = grant_dir;
    clr_in = 1'b0;
    clr_out = 1'b0;
    rej_n = 1'b0;
    to_n = 1'b0;
    case (state)
      IDLE: state_n = (pend_in || pend_out) ? ARB : IDLE;
      ARB: begin
        clr_in = sel == DIR_ENTRY;
        clr_out = sel == DIR_EXIT;
        rej_n = !feasible;
        grant_n = feasible ? sel : grant_dir;
        timer_n = feasible ? TW'(PASS_TIMEOUT) : timer;
        state_n = feasible ? OPEN : IDLE;
      end
      OPEN: begin
        // a pass seen in the final open cycle beats the timeout
        if (pass_q) begin
          occ_n = (grant_dir == DIR_EXIT) ? occupancy - OW'(1) : occupancy + OW'(1);
          timer_n = TW'(HOLDOFF);
          state_n = HOLD;
        end else if (timer <= TW'(1)) begin
          to_n = 1'b1;
          timer_n = TW'(HOLDOFF);
          state_n = HOLD;
        end else timer_n = timer - TW'(1);
      end
      HOLD: begin
        state_n = (timer <= TW'(1)) ? IDLE : HOLD;
        timer_n = (timer <= TW'(1)) ? timer : timer - TW'(1);
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      occupancy <= '0;
      pend_in <= 1'b0;
      pend_out <= 1'b0;
      pass_q <= 1'b0;
      gate_open <= 1'b0;
      grant_dir <= DIR_ENTRY;
      reject <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      occupancy <= occ_n;
      pend_in <= pend_in ? ~clr_in : in_rise;
      pend_out <= pend_out ? ~clr_out : out_rise;
      pass_q <= pass_rise && state == OPEN;
      gate_open <= state_n == OPEN;
      grant_dir <= grant_n;
      reject <= rej_n;
      timeout <= to_n;
    end
  always_ff @(posedge clk)
    if (!rst && state == OPEN && pass_q)
      assert ((grant_dir == DIR_EXIT) ? !empty : !full);
endmodule

// File: tb/tb_parking_gate_controller.sv
// tb_parking_gate_controller: randomized scoreboard bench against a transaction-level lot model.
module tb_parking_gate_controller;
  import parking_pkg::*;
  localparam int CAP = 2, PT = 20, HO = 4, OW = occ_width(CAP);
  logic clk = 0, rst = 1, entry_req = 0, exit_req = 0, car_passed = 0;
  logic gate_open, grant_dir, reject, timeout, full, empty;
  logic [OW-1:0] occupancy;
  parking_gate_controller #(.CAPACITY(CAP), .PASS_TIMEOUT(PT), .HOLDOFF(HO)) dut (
    .clk(clk), .rst(rst), .entry_req(entry_req), .exit_req(exit_req), .car_passed(car_passed),
    .gate_open(gate_open), .grant_dir(grant_dir), .reject(reject), .timeout(timeout),
    .occupancy(occupancy), .full(full), .empty(empty)
  );
  always #5 clk = ~clk;
  typedef struct {int dir; int occ; int cyc;} ev_t;
  ev_t grant_q[$], close_q[$], reject_q[$], timeout_q[$];
  int total = 0, bad = 0, cyc = 0, last_close = 0, open_len = 0;
  int m_occ = 0, m_last = 1;
  logic prev_gate = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // grant cyc: >=0 exact cycle, -2 holdoff after previous close, -1 unchecked; close cyc: open length
  always @(negedge clk) begin : mon
    ev_t e;
    if (gate_open && !prev_gate) begin
      check("grant_expected", int'(grant_q.size() > 0), 1);
      if (grant_q.size() > 0) begin
        e = grant_q.pop_front();
        check("grant_dir", grant_dir, e.dir);
        if (e.cyc >= 0) check("grant_cycle", cyc, e.cyc);
        else if (e.cyc == -2) check("grant_after_hold", cyc, last_close + HO + 2);
      end
      open_len = 0;
    end
    if (gate_open) open_len++;
    if (!gate_open && prev_gate) begin
      last_close = cyc;
      check("close_expected", int'(close_q.size() > 0), 1);
      if (close_q.size() > 0) begin
        e = close_q.pop_front();
        check("close_occ", occupancy, e.occ);
        check("close_full", full, int'(e.occ == CAP));
        check("close_empty", empty, int'(e.occ == 0));
        if (e.cyc >= 0) check("open_len", open_len, e.cyc);
      end
    end
    if (reject) begin
      check("reject_expected", int'(reject_q.size() > 0), 1);
      if (reject_q.size() > 0) begin
        e = reject_q.pop_front();
        check("reject_occ", occupancy, e.occ);
        check("reject_gate", gate_open, 0);
      end
    end
    if (timeout) begin
      check("timeout_expected", int'(timeout_q.size() > 0), 1);
      if (timeout_q.size() > 0) begin
        e = timeout_q.pop_front();
        check("timeout_occ", occupancy, e.occ);
      end
    end
    prev_gate = gate_open;
  end
  task automatic request(input logic en, input logic ex, output int n);
    @(negedge clk);
    entry_req = en;
    exit_req = ex;
    n = cyc + 1;
    repeat (2) @(negedge clk);
    entry_req = 0;
    exit_req = 0;
  endtask
  task automatic wait_gate(input logic lvl);
    int k = 0;
    while (gate_open !== lvl && k < 80) begin
      @(negedge clk);
      k++;
    end
    if (gate_open !== lvl) check("gate_wait", gate_open, lvl);
  endtask
  function automatic bit infeasible(input int d);
    return d == 1 ? m_occ == 0 : m_occ == CAP;
  endfunction
  task automatic serve(input int dir, input bit pass, input int j);
    wait_gate(1);
    if (pass) begin
      repeat (j) @(negedge clk);
      car_passed = 1;
      m_occ += dir == 1 ? -1 : 1;
      close_q.push_back('{dir, m_occ, 3 + j});
      @(negedge clk);
      car_passed = 0;
    end else begin
      close_q.push_back('{dir, m_occ, PT});
      timeout_q.push_back('{dir, m_occ, -1});
    end
    wait_gate(0);
  endtask
  task automatic transact(input int dir, input bit pass, input int j);
    int n;
    request(dir == 0, dir == 1, n);
    if (infeasible(dir)) reject_q.push_back('{dir, m_occ, -1});
    else begin
      grant_q.push_back('{dir, m_occ, n + 3});
      m_last = dir;
      serve(dir, pass, j);
    end
    repeat (HO + 4) @(negedge clk);
  endtask
  task automatic tie(input int j);
    int n, first;
    bit granted = 0;
    request(1, 1, n);
`ifdef PARK_EXIT_PRIORITY_EN
    first = 1;
`else
    first = 1 - m_last;
`endif
    for (int k = 0; k < 2; k++) begin
      int d = k == 0 ? first : 1 - first;
      if (infeasible(d)) reject_q.push_back('{d, m_occ, -1});
      else begin
        grant_q.push_back('{d, m_occ, k == 0 ? n + 3 : (granted ? -2 : -1)});
        m_last = d;
        granted = 1;
        serve(d, 1, j);
      end
    end
    repeat (HO + 4) @(negedge clk);
  endtask
  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_gate", gate_open, 0);
    check("rst_occ", occupancy, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_reject", reject, 0);
    check("rst_timeout", timeout, 0);
    rst = 0;
    repeat (2) @(negedge clk);
    transact(0, 1, 4);
    check("empty_fell", empty, 0);
    transact(0, 1, 0);
    check("full_at_cap", full, 1);
    transact(0, 1, 3);
    check("occ_after_full_reject", occupancy, 2);
    transact(1, 1, 2);
    tie(1);
    transact(1, 1, 6);
    transact(1, 1, 1);
    check("empty_low_water", empty, 1);
    transact(1, 1, 1);
    transact(0, 0, 0);
    transact(0, 1, 17);
    request(1, 0, n);
    grant_q.push_back('{0, m_occ, n + 3});
    wait_gate(1);
    exit_req = 1;
    repeat (2) @(negedge clk);
    exit_req = 0;
    close_q.push_back('{0, 0, -1});
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("midrst_gate", gate_open, 0);
    check("midrst_occ", occupancy, 0);
    check("midrst_empty", empty, 1);
    m_occ = 0;
    m_last = 1;
    repeat (30) @(negedge clk);
    for (int i = 0; i < 50; i++) begin
      if ($urandom_range(0, 9) < 2) tie($urandom_range(0, 17));
      else transact($urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 17));
    end
    repeat (10) @(negedge clk);
    check("grant_q_left", grant_q.size(), 0);
    check("close_q_left", close_q.size(), 0);
    check("reject_q_left", reject_q.size(), 0);
    check("timeout_q_left", timeout_q.size(), 0);
    check("final_occ", occupancy, m_occ);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end
endmodule
